// File: rtl/ddr3_wr_dq_feed.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_wr_dq_feed
// Purpose  : SCLK-domain feed for the 4:1 DDR3 write-path output serializers.
//            Buffers controller write words and releases each BL8 burst
//            (two 4-beat words) exactly WL_SCLK cycles after the WRITE
//            command, along with DQ/DQS output enables and the DQS pattern.
// Revision : 1.0 - initial release
// ============================================================================
module ddr3_wr_dq_feed #(
    parameter int DQ_W       = 8,
    parameter int DM_W       = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int WL_SCLK    = 3
) (
    input  logic                SCLK,
    input  logic                RSTB,
    input  logic                wr_data_valid,
    output logic                wr_data_ready,
    input  logic [4*DQ_W-1:0]   wr_data,
    input  logic [4*DM_W-1:0]   wr_mask,
    input  logic                wr_cmd,
    output logic [DQ_W-1:0]     dq_d0,
    output logic [DQ_W-1:0]     dq_d1,
    output logic [DQ_W-1:0]     dq_d2,
    output logic [DQ_W-1:0]     dq_d3,
    output logic [DM_W-1:0]     dm_d0,
    output logic [DM_W-1:0]     dm_d1,
    output logic [DM_W-1:0]     dm_d2,
    output logic [DM_W-1:0]     dm_d3,
    output logic                dq_oe,
    output logic                dqs_oe,
    output logic [3:0]          dqs_d,
    output logic                busy,
    output logic                err_underrun,
    output logic                err_ccd
);

    localparam int              c_AW      = $clog2(FIFO_DEPTH);
    localparam int              c_DW      = 4 * DQ_W;
    localparam int              c_MW      = 4 * DM_W;
    localparam int              c_WW      = c_DW + c_MW;
    localparam logic [c_AW:0]   c_PTR_ONE = 1;
    localparam logic [3:0]      c_DQS_PAT = 4'b0101;

    // Write latency below 2 leaves no room for the DQS preamble slot.
    generate
        if (WL_SCLK < 2 || WL_SCLK > 15) begin : g_bad_wl
            $error("ddr3_wr_dq_feed: WL_SCLK must be in 2..15");
        end
    endgenerate

    // FIFO storage: each entry is {mask, data}
    logic [c_WW-1:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;

    // Launch pipeline and burst tracking
    logic [WL_SCLK-1:0] r_tok;
    logic               r_second;   // second word of a burst is due next edge
    logic               r_post;     // second word is on the outputs now
    logic               w_cmd_ok;
    logic               w_pop_req;

    // Registered serializer-side outputs
    logic [c_DW-1:0]    r_dq;
    logic [c_MW-1:0]    r_dm;
    logic               r_dq_oe;
    logic               r_dqs_oe;
    logic [3:0]         r_dqs_d;
    logic               r_err_udr;
    logic               r_err_ccd;

    assign w_empty       = (r_wptr == r_rptr);
    assign w_full        = (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]) &&
                           (r_wptr[c_AW] != r_rptr[c_AW]);
    assign wr_data_ready = !w_full;
    assign w_push        = wr_data_valid && !w_full;

    // A word is due when a token reaches the pipeline end, and again one cycle later.
    assign w_pop_req     = r_tok[WL_SCLK-1] | r_second;
    assign w_pop         = w_pop_req && !w_empty;

    // A token inserted on the previous edge is still in stage 0: too close, drop.
    assign w_cmd_ok      = wr_cmd && !r_tok[0];

    // FIFO data array, written on accepted pushes only
    always_ff @(posedge SCLK) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= {wr_mask, wr_data};
        end
    end

    // FIFO pointers
    always_ff @(posedge SCLK) begin
        if (RSTB) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    // Launch token shift register and burst phase tracking
    always_ff @(posedge SCLK) begin
        if (RSTB) begin
            r_tok    <= '0;
            r_second <= 1'b0;
            r_post   <= 1'b0;
        end else begin
            r_tok    <= {r_tok[WL_SCLK-2:0], w_cmd_ok};
            r_second <= r_tok[WL_SCLK-1];
            r_post   <= r_second;
        end
    end

    // Output register: data/mask, enables, DQS pattern and sticky errors
    always_ff @(posedge SCLK) begin
        if (RSTB) begin
            r_dq      <= '0;
            r_dm      <= '0;
            r_dq_oe   <= 1'b0;
            r_dqs_oe  <= 1'b0;
            r_dqs_d   <= 4'b0000;
            r_err_udr <= 1'b0;
            r_err_ccd <= 1'b0;
        end else begin
            r_dq_oe  <= w_pop_req;
            // preamble (one before data), both data cycles, postamble (one after)
            r_dqs_oe <= r_tok[WL_SCLK-2] | w_pop_req | r_post;
            r_dqs_d  <= w_pop_req ? c_DQS_PAT : 4'b0000;
            if (!w_pop_req) begin
                r_dq <= '0;
                r_dm <= '0;
            end else if (w_empty) begin
                // missing word: drive zeros and mask every byte
                r_dq <= '0;
                r_dm <= '1;
            end else begin
                {r_dm, r_dq} <= r_mem[r_rptr[c_AW-1:0]];
            end
            if (w_pop_req && w_empty) r_err_udr <= 1'b1;
            if (wr_cmd && r_tok[0])   r_err_ccd <= 1'b1;
        end
    end

    assign dq_d0        = r_dq[0*DQ_W +: DQ_W];
    assign dq_d1        = r_dq[1*DQ_W +: DQ_W];
    assign dq_d2        = r_dq[2*DQ_W +: DQ_W];
    assign dq_d3        = r_dq[3*DQ_W +: DQ_W];
    assign dm_d0        = r_dm[0*DM_W +: DM_W];
    assign dm_d1        = r_dm[1*DM_W +: DM_W];
    assign dm_d2        = r_dm[2*DM_W +: DM_W];
    assign dm_d3        = r_dm[3*DM_W +: DM_W];
    assign dq_oe        = r_dq_oe;
    assign dqs_oe       = r_dqs_oe;
    assign dqs_d        = r_dqs_d;
    assign err_underrun = r_err_udr;
    assign err_ccd      = r_err_ccd;
    assign busy         = (|r_tok) | r_second | r_post | r_dq_oe | r_dqs_oe;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_wr_dq_feed.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_wr_dq_feed
// Purpose  : Scoreboard bench for ddr3_wr_dq_feed. The stimulus side keeps a
//            cycle-indexed model of burst timing and a word queue for the
//            FIFO; the monitor compares every SCLK against those.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr3_wr_dq_feed;

    localparam int DQ_W       = 8;
    localparam int DM_W       = 1;
    localparam int FIFO_DEPTH = 8;
    localparam int WL         = 3;
    localparam int MAXE       = 8192;

    logic        SCLK = 1'b0;
    logic        RSTB = 1'b1;
    logic        wr_data_valid = 1'b0;
    logic        wr_data_ready;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic        wr_cmd = 1'b0;
    logic [7:0]  dq_d0, dq_d1, dq_d2, dq_d3;
    logic [0:0]  dm_d0, dm_d1, dm_d2, dm_d3;
    logic        dq_oe, dqs_oe, busy, err_underrun, err_ccd;
    logic [3:0]  dqs_d;

    ddr3_wr_dq_feed #(
        .DQ_W(DQ_W), .DM_W(DM_W), .FIFO_DEPTH(FIFO_DEPTH), .WL_SCLK(WL)
    ) dut (
        .SCLK(SCLK), .RSTB(RSTB),
        .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .wr_data(wr_data), .wr_mask(wr_mask), .wr_cmd(wr_cmd),
        .dq_d0(dq_d0), .dq_d1(dq_d1), .dq_d2(dq_d2), .dq_d3(dq_d3),
        .dm_d0(dm_d0), .dm_d1(dm_d1), .dm_d2(dm_d2), .dm_d3(dm_d3),
        .dq_oe(dq_oe), .dqs_oe(dqs_oe), .dqs_d(dqs_d), .busy(busy),
        .err_underrun(err_underrun), .err_ccd(err_ccd)
    );

    always #5 SCLK = ~SCLK;

    int edge_cnt = 0;
    always @(posedge SCLK) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-edge expectations plus the word queue
    bit          pop_at  [MAXE];
    bit          dqs_at  [MAXE];
    bit          busy_at [MAXE];
    logic [35:0] mq[$];
    logic [35:0] exp_q[$];
    bit          m_ccd = 0;
    bit          m_udr = 0;
    bit          m_rdy = 1;
    int          last_ins = -100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_cnt, act, expv);
        end
    endtask

    // One SCLK of stimulus; the model advances to the state after the coming edge.
    task automatic step(input bit v, input logic [31:0] d, input logic [3:0] m,
                        input bit c, input bit r);
        int e;
        bit was_full;
        @(negedge SCLK);
        #1;
        e = edge_cnt + 1;
        RSTB = r; wr_data_valid = v; wr_data = d; wr_mask = m; wr_cmd = c;
        if (r) begin
            mq.delete();
            m_ccd = 0; m_udr = 0; last_ins = -100;
            for (int k = e; k < e + WL + 4; k++) begin
                pop_at[k] = 0; dqs_at[k] = 0; busy_at[k] = 0;
            end
        end else begin
            was_full = (mq.size() == FIFO_DEPTH);
            if (c) begin
                if (last_ins == e - 1) m_ccd = 1;
                else begin
                    last_ins = e;
                    pop_at[e+WL] = 1; pop_at[e+WL+1] = 1;
                    for (int k = e + WL - 1; k <= e + WL + 2; k++) dqs_at[k] = 1;
                    for (int k = e; k <= e + WL + 2; k++) busy_at[k] = 1;
                end
            end
            if (pop_at[e]) begin
                if (mq.size() == 0) begin
                    exp_q.push_back({4'hF, 32'h0});
                    m_udr = 1;
                end else begin
                    exp_q.push_back(mq.pop_front());
                end
            end
            if (v && !was_full) mq.push_back({m, d});
        end
        m_rdy = (mq.size() < FIFO_DEPTH);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] m);
        step(1, d, m, 0, 0);
    endtask

    // Monitor: per-edge timing checks, and scoreboard pops on every data cycle
    logic [35:0] mon_w;
    int          mon_n;
    initial begin
        forever begin
            @(negedge SCLK);
            if (edge_cnt >= 1) begin
                mon_n = edge_cnt;
                chk("dq_oe", dq_oe, pop_at[mon_n]);
                chk("dqs_oe", dqs_oe, dqs_at[mon_n]);
                chk("dqs_d", dqs_d, pop_at[mon_n] ? 4'b0101 : 4'b0000);
                chk("busy", busy, busy_at[mon_n]);
                chk("err_ccd", err_ccd, m_ccd);
                chk("err_underrun", err_underrun, m_udr);
                chk("wr_data_ready", wr_data_ready, m_rdy);
                if (dq_oe === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("word_expected", 1'b0, 1'b1);
                    end else begin
                        mon_w = exp_q.pop_front();
                        chk("dq_word", {dq_d3, dq_d2, dq_d1, dq_d0}, mon_w[31:0]);
                        chk("dm_word", {dm_d3, dm_d2, dm_d1, dm_d0}, mon_w[35:32]);
                    end
                end else begin
                    chk("idle_bus", {dq_d3, dq_d2, dq_d1, dq_d0, dm_d3, dm_d2, dm_d1, dm_d0}, 36'h0);
                end
            end
        end
    end

    initial begin
        // reset
        for (int i = 0; i < 3; i++) step(0, 32'h0, 4'h0, 0, 1);
        idle(2);
        // single burst with known data
        push(32'h33221100, 4'h0);
        push(32'h77665544, 4'h0);
        idle(1);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(7);
        // back-to-back bursts at 2-cycle spacing
        push(32'hA3A2A1A0, 4'h0); push(32'hB3B2B1B0, 4'h1);
        push(32'hC3C2C1C0, 4'h2); push(32'hD3D2D1D0, 4'h8);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(1);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(8);
        // tCCD violation: second command dropped
        push(32'h01020304, 4'h0); push(32'h05060708, 4'h0);
        step(0, 32'h0, 4'h0, 1, 0);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(8);
        // underrun with one word queued
        step(0, 32'h0, 4'h0, 0, 1);
        push(32'hDEADBEEF, 4'h5);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(7);
        // fill to full, rejected push, drain while refilling
        step(0, 32'h0, 4'h0, 0, 1);
        for (int i = 0; i < FIFO_DEPTH; i++) push(32'h10101010 * (i + 1), 4'(i));
        push(32'hBADBAD00, 4'hF);
        step(1, 32'hBADBAD00, 4'hF, 1, 0);
        push(32'hBADBAD00, 4'hF);
        step(0, 32'h0, 4'h0, 1, 0);
        push(32'h99999999, 4'h3);
        push(32'hAAAAAAAA, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(0, 32'h0, 4'h0, 1, 0);
            idle(1);
        end
        idle(8);
        // reset in the middle of a burst
        push(32'h11112222, 4'h0); push(32'h33334444, 4'h0);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(3);
        step(0, 32'h0, 4'h0, 0, 1);
        idle(2);
        step(0, 32'h0, 4'h0, 1, 0);
        idle(7);
        step(0, 32'h0, 4'h0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
        end
        idle(10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr3_wr_dq_feed.md
Name: ddr3_wr_dq_feed

Overview:
- Upstream feed for the per-bit 4:1 DDR output serializers on the DDR3 write path, in the SCLK domain.
- Buffers controller write data and releases each BL8 burst exactly WL_SCLK cycles after the write command.
- Drives the D0..D3 data and mask buses, the DQ/DQS tristate enables and the DQS pattern bits.
- Per SCLK, one 4-beat word is emitted. D0 is the first beat on the pin.

Parameters:
- DQ_W, 8, DQ bits per byte lane group
- DM_W, 1, mask bits (one per 8 DQ)
- FIFO_DEPTH, 8, data FIFO depth in 4-beat words (power of 2, >=4)
- WL_SCLK, 3, write latency in SCLK cycles from command to first data word (2..15)

Ports:
- SCLK  in  1  system clock, all logic on rising edge
- RSTB  in  1  reset, synchronous, active-high
- wr_data_valid  in  1  write data word offered
- wr_data_ready  out  1  FIFO can accept a word
- wr_data  in  4*DQ_W  beats 0..3; beat k at [k*DQ_W +: DQ_W]
- wr_mask  in  4*DM_W  mask per beat, same packing
- wr_cmd  in  1  one-cycle pulse: WRITE (BL8) issued to DRAM this cycle
- dq_d0, dq_d1, dq_d2, dq_d3  out  DQ_W each  serializer data, beat 0..3
- dm_d0, dm_d1, dm_d2, dm_d3  out  DM_W each  serializer mask, beat 0..3
- dq_oe  out  1  DQ/DM output enable (1 = drive)
- dqs_oe  out  1  DQS output enable
- dqs_d  out  4  DQS beat pattern, bit k = beat k
- busy  out  1  any burst pending or in flight
- err_underrun  out  1  sticky: data word missing at pop
- err_ccd  out  1  sticky: wr_cmd spacing violation

Behaviour:
- Reset, synchronous on RSTB=1:
  - FIFO flushed; launch pipeline cleared.
  - All d/dm buses and dqs_d = 0; dq_oe = dqs_oe = 0; busy = 0; both error flags = 0.
  - Reset mid-burst: outputs are 0 after that edge, and the burst is abandoned.
- FIFO:
  - Push on wr_data_valid & wr_data_ready; wr_data_ready = !full.
  - Ready is computed from full only, so no push-through while a pop is in the same cycle.
  - Word order is preserved. Push and pop in the same cycle are both legal.
- Command pipeline:
  - WL_SCLK-deep shift register of launch tokens, shifted every cycle.
  - wr_cmd sampled at edge t inserts a token.
  - A wr_cmd arriving while a token was inserted at edge t-1 (spacing < 2 SCLK, tCCD violation) is dropped and sets err_ccd.
- Data timing, for wr_cmd sampled at edge t:
  - After edge t+WL_SCLK, outputs hold FIFO word 0. After edge t+WL_SCLK+1, they hold word 1.
  - Pops occur at those same edges; outputs are registered.
  - In non-data cycles, dq_d* = 0, dm_d* = 0 and dq_oe = 0.
- dq_oe: 1 exactly during the two data cycles.
- dqs_oe:
  - Additionally 1 one cycle before data (preamble, edge t+WL_SCLK-1) and one cycle after (postamble, edge t+WL_SCLK+2).
  - Back-to-back bursts at exactly 2-cycle spacing keep dq_oe and dqs_oe continuously high; no pre/postamble gap is inserted.
- dqs_d: 4'b0101 (beat0 = 1) in data cycles; 4'b0000 in preamble, postamble and idle.
- Underrun:
  - Applies if the FIFO is empty at a required pop.
  - That word's outputs are dq_d* = 0 and dm_d* = all ones, masking the write.
  - dq_oe still follows the timing. err_underrun is set.
  - Remaining pops continue normally.
- Error flags: cleared only by RSTB.
- busy: 1 while any token is in the pipeline, any data cycle is active, or dqs_oe = 1.
- WL_SCLK < 2 is illegal: an elaboration-time check fails.

Test Plan:
- Reset with RSTB=1 mid-burst -> next edge: all outputs 0, wr_data_ready=1, errors 0, FIFO empty (following wr_cmd underruns).
- Push words 0x33221100 and 0x77665544 (DQ_W=8), mask 0; wr_cmd at edge 10 with WL_SCLK=3:
  - dqs_oe=1 from edge 12.
  - After edge 13: dq_d0..d3 = 00,11,22,33 with dq_oe=1 and dqs_d=0101.
  - After edge 14: 44,55,66,77.
  - After edge 15: dq_oe=0, dqs_oe=1 (postamble). After edge 16: all 0.
- Two wr_cmd at edges 10 and 12 with 4 words queued -> dq_oe high continuously after edges 13..16; dqs_oe high 12..17, no gap.
- wr_cmd at 10 and 11 -> second dropped, err_ccd=1, only 2 words popped.
- wr_cmd with FIFO holding 1 word -> first cycle real data; second cycle dq_d*=0, dm_d*=1, err_underrun=1.
- Fill FIFO to 8 words -> wr_data_ready=0. A push attempt is not accepted. After a pop, ready returns 1 next cycle and order is intact.
